handshake_burst_accum: RTL and testbench

Downstream consumer of the 32-bit valid/ready stream produced by the patting handshake pipe. It accepts words in fixed-length bursts of BURST_LEN, accumulates an unsigned sum and the unsigned maximum of each burst, and presents one result per burst on a registered valid/ready output port. The accumulator and the result register are separate, so the next burst accumulates while the previous result waits for the consumer.

---
 rtl/handshake_burst_accum_pkg.sv | 39 +++
 rtl/handshake_burst_accum_if.sv | 34 +++
 rtl/handshake_burst_accum.sv | 118 +++++++++++
 tb/tb_handshake_burst_accum.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_burst_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_burst_accum_pkg
// Description : Shared constants, phase encoding and helpers for the burst
//               accumulator and its stream interface.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_burst_accum_pkg;

    // Word width shared with the upstream handshake pipe.
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_MID   = 2'd1,
        PH_LAST  = 2'd2
    } phase_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Wide enough that BURST_LEN full-scale words can never overflow.
    function automatic int sum_width(input int burst_len);
        return c_DATA_W + clog2(burst_len);
    endfunction

    function automatic logic [c_DATA_W-1:0] umax(input logic [c_DATA_W-1:0] a,
                                                 input logic [c_DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage : handshake_burst_accum_pkg
`default_nettype wire

// File: rtl/handshake_burst_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : handshake_burst_accum_if
// Description : Input word stream and output result stream of the burst
//               accumulator, with producer/consumer (master) and DUT (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface handshake_burst_accum_if
    import handshake_burst_accum_pkg::*;
#(
    parameter int BURST_LEN = 4
);
    localparam int SUM_W = sum_width(BURST_LEN);

    logic                s_valid;
    logic [c_DATA_W-1:0] s_data;
    logic                s_ready;
    logic                m_valid;
    logic [SUM_W-1:0]    m_sum;
    logic [c_DATA_W-1:0] m_max;
    logic                m_ready;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_sum, m_max
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_sum, m_max
    );

endinterface : handshake_burst_accum_if
`default_nettype wire

// File: rtl/handshake_burst_accum.sv
`default_nettype none
// ============================================================================
// Module      : handshake_burst_accum
// Description : Accumulates sum and unsigned max over fixed-length bursts and
//               presents one registered result per burst.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_burst_accum
    import handshake_burst_accum_pkg::*;
#(
    parameter int BURST_LEN = 4
)(
    input  logic                    clk,
    input  logic                    rst_n,
    handshake_burst_accum_if.slave  io_bus
);

    localparam int               SUM_W      = sum_width(BURST_LEN);
    localparam int               CNT_W      = clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [SUM_W-1:0]    r_acc_sum;
    logic [c_DATA_W-1:0] r_acc_max;
    logic                r_m_valid;
    logic [SUM_W-1:0]    r_m_sum;
    logic [c_DATA_W-1:0] r_m_max;

    phase_t              w_phase;
    logic                w_s_ready;
    logic                w_in_hs;
    logic                w_out_hs;
    logic [c_DATA_W-1:0] w_data;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SUM_W-1:0]    w_acc_sum_nxt;
    logic [c_DATA_W-1:0] w_acc_max_nxt;
    logic                w_m_valid_nxt;
    logic [SUM_W-1:0]    w_m_sum_nxt;
    logic [c_DATA_W-1:0] w_m_max_nxt;

    // Only the closing word of a burst has to wait for an untaken result.
    assign w_s_ready = ~(r_m_valid & (r_cnt == c_CNT_LAST));
    assign w_in_hs   = io_bus.s_valid & w_s_ready;
    assign w_out_hs  = r_m_valid & io_bus.m_ready;
    assign w_data    = io_bus.s_data;

    always_comb begin
        if (r_cnt == c_CNT_LAST) begin
            w_phase = PH_LAST;
        end else if (r_cnt == '0) begin
            w_phase = PH_FIRST;
        end else begin
            w_phase = PH_MID;
        end
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_acc_sum_nxt = r_acc_sum;
        w_acc_max_nxt = r_acc_max;
        w_m_valid_nxt = r_m_valid;
        w_m_sum_nxt   = r_m_sum;
        w_m_max_nxt   = r_m_max;

        if (w_out_hs) begin
            w_m_valid_nxt = 1'b0;
        end

        if (w_in_hs) begin
            case (w_phase)
                PH_FIRST: begin
                    w_acc_sum_nxt = SUM_W'(w_data);
                    w_acc_max_nxt = w_data;
                    w_cnt_nxt     = CNT_W'(1);
                end
                PH_MID: begin
                    w_acc_sum_nxt = r_acc_sum + SUM_W'(w_data);
                    w_acc_max_nxt = umax(r_acc_max, w_data);
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
                PH_LAST: begin
                    w_m_sum_nxt   = r_acc_sum + SUM_W'(w_data);
                    w_m_max_nxt   = umax(r_acc_max, w_data);
                    w_m_valid_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end
                default: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc_sum <= '0;
            r_acc_max <= '0;
            r_m_valid <= 1'b0;
            r_m_sum   <= '0;
            r_m_max   <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_acc_sum <= w_acc_sum_nxt;
            r_acc_max <= w_acc_max_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_sum   <= w_m_sum_nxt;
            r_m_max   <= w_m_max_nxt;
        end
    end

    assign io_bus.s_ready = w_s_ready;
    assign io_bus.m_valid = r_m_valid;
    assign io_bus.m_sum   = r_m_sum;
    assign io_bus.m_max   = r_m_max;

endmodule : handshake_burst_accum
`default_nettype wire

// File: tb/tb_handshake_burst_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_burst_accum
// Description : Directed and randomized bench for handshake_burst_accum with a
//               queue-based burst model; also covers a BURST_LEN=2 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_burst_accum;
    import handshake_burst_accum_pkg::*;

    localparam int BL  = 4;
    localparam int BL2 = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    handshake_burst_accum_if #(.BURST_LEN(BL))  hbus ();
    handshake_burst_accum_if #(.BURST_LEN(BL2)) hbus2 ();

    handshake_burst_accum #(.BURST_LEN(BL)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (hbus.slave)
    );

    handshake_burst_accum #(.BURST_LEN(BL2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (hbus2.slave)
    );

    int checks = 0;
    int errors = 0;
    bit rand_mready = 1'b0;

    logic [31:0] q_words[$];
    logic [63:0] q_sum[$];
    logic [31:0] q_max[$];
    logic [63:0] r2_sum[$];
    logic [31:0] r2_max[$];
    bit          prev_hold = 1'b0;
    logic [63:0] prev_sum;
    logic [31:0] prev_max;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Model: collect accepted words; every BURST_LEN of them yields one result.
    always @(negedge clk) begin : p_model
        logic [63:0] s;
        logic [31:0] mx;
        if (!rst_n) begin
            q_words.delete();
            q_sum.delete();
            q_max.delete();
            prev_hold = 1'b0;
        end else begin
            check("m_valid_vs_model", 64'(hbus.m_valid), 64'(q_sum.size() > 0));
            check("s_ready_vs_model", 64'(hbus.s_ready),
                  64'(!(q_sum.size() > 0 && q_words.size() == BL - 1)));
            if (prev_hold) begin
                check("hold_sum", 64'(hbus.m_sum), prev_sum);
                check("hold_max", 64'(hbus.m_max), 64'(prev_max));
            end
            if (hbus.m_valid && hbus.m_ready && q_sum.size() > 0) begin
                check("result_sum", 64'(hbus.m_sum), q_sum.pop_front());
                check("result_max", 64'(hbus.m_max), 64'(q_max.pop_front()));
            end
            if (hbus.s_valid && hbus.s_ready) begin
                q_words.push_back(hbus.s_data);
                if (q_words.size() == BL) begin
                    s  = 64'd0;
                    mx = 32'd0;
                    foreach (q_words[i]) begin
                        s = s + 64'(q_words[i]);
                        if (q_words[i] > mx) mx = q_words[i];
                    end
                    q_sum.push_back(s);
                    q_max.push_back(mx);
                    q_words.delete();
                end
            end
            prev_hold = hbus.m_valid && !hbus.m_ready;
            prev_sum  = 64'(hbus.m_sum);
            prev_max  = hbus.m_max;
        end
    end

    always @(negedge clk) begin
        if (rst_n && hbus2.m_valid && hbus2.m_ready) begin
            r2_sum.push_back(64'(hbus2.m_sum));
            r2_max.push_back(hbus2.m_max);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mready) hbus.m_ready = 1'($urandom_range(1, 0));
    endtask

    task automatic send(input logic [31:0] d, input bit gaps, output int stalls);
        int guard;
        stalls = 0;
        guard  = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                hbus.s_valid = 1'b0;
                tick();
            end
        end
        hbus.s_valid = 1'b1;
        hbus.s_data  = d;
        while (hbus.s_ready !== 1'b1 && guard < 200) begin
            stalls++;
            guard++;
            tick();
        end
        check("send_accepted", 64'(hbus.s_ready), 64'd1);
        tick();
    endtask

    task automatic wait_result(input string tag, input logic [63:0] es, input logic [31:0] em);
        int g = 0;
        while (hbus.m_valid !== 1'b1 && g < 50) begin
            g++;
            tick();
        end
        check({tag, "_valid"}, 64'(hbus.m_valid), 64'd1);
        check({tag, "_sum"},   64'(hbus.m_sum),   es);
        check({tag, "_max"},   64'(hbus.m_max),   64'(em));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(hbus.m_valid), 64'd0);
        check({tag, "_m_sum"},   64'(hbus.m_sum),   64'd0);
        check({tag, "_m_max"},   64'(hbus.m_max),   64'd0);
        check({tag, "_s_ready"}, 64'(hbus.s_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int          st;
        int          stall_total;
        logic [31:0] d;
        logic [31:0] b1 [4];
        int          g;

        rst_n         = 1'b0;
        hbus.s_valid  = 1'b0;
        hbus.s_data   = 32'd0;
        hbus.m_ready  = 1'b1;
        hbus2.s_valid = 1'b0;
        hbus2.s_data  = 32'd0;
        hbus2.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset2_m_valid", 64'(hbus2.m_valid), 64'd0);
        check("reset2_s_ready", 64'(hbus2.s_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // 1,2,3,4 back-to-back
        stall_total = 0;
        for (int i = 1; i <= 4; i++) begin
            send(32'(i), 1'b0, st);
            stall_total += st;
        end
        hbus.s_valid = 1'b0;
        check("t1_valid", 64'(hbus.m_valid), 64'd1);
        check("t1_sum",   64'(hbus.m_sum),   64'd10);
        check("t1_max",   64'(hbus.m_max),   64'd4);
        check("t1_no_stall", 64'(stall_total), 64'd0);
        tick();
        check("t1_one_cycle", 64'(hbus.m_valid), 64'd0);

        // full-scale words
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0, st);
        hbus.s_valid = 1'b0;
        wait_result("t2", 64'h3_FFFF_FFFC, 32'hFFFF_FFFF);
        tick();

        // back-pressure: result held while next burst accumulates
        hbus.m_ready = 1'b0;
        b1[0] = 32'd5; b1[1] = 32'd9; b1[2] = 32'd2; b1[3] = 32'd7;
        for (int i = 0; i < 4; i++) send(b1[i], 1'b0, st);
        hbus.s_valid = 1'b0;
        wait_result("t3a", 64'd23, 32'd9);
        stall_total = 0;
        for (int i = 0; i < 3; i++) begin
            send(32'd1, 1'b0, st);
            stall_total += st;
        end
        check("t3_three_accepted", 64'(stall_total), 64'd0);
        hbus.s_valid = 1'b1;
        hbus.s_data  = 32'd1;
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_ready", 64'(hbus.s_ready), 64'd0);
            check("t3_held_sum",    64'(hbus.m_sum),   64'd23);
            tick();
        end
        hbus.m_ready = 1'b1;
        tick();
        check("t3_valid_fell", 64'(hbus.m_valid), 64'd0);
        check("t3_ready_back", 64'(hbus.s_ready), 64'd1);
        tick();
        hbus.s_valid = 1'b0;
        wait_result("t3b", 64'd4, 32'd1);
        tick();
        check("t3_done", 64'(hbus.m_valid), 64'd0);

        // random gaps
        b1[0] = 32'd10; b1[1] = 32'd0; b1[2] = 32'd30; b1[3] = 32'd20;
        for (int i = 0; i < 4; i++) send(b1[i], 1'b1, st);
        hbus.s_valid = 1'b0;
        wait_result("t4", 64'd60, 32'd30);
        tick();

        // random words, gaps and downstream back-pressure, checked by the model
        rand_mready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int w = 0; w < BL; w++) begin
                d = $urandom;
                if ($urandom_range(3, 0) == 0) d = 32'hFFFF_FFFF;
                send(d, 1'b1, st);
            end
        end
        hbus.s_valid = 1'b0;
        rand_mready  = 1'b0;
        hbus.m_ready = 1'b1;
        g = 0;
        while ((q_sum.size() > 0 || hbus.m_valid) && g < 50) begin
            g++;
            tick();
        end
        check("t5_drained",  64'(q_sum.size()),   64'd0);
        check("t5_no_words", 64'(q_words.size()), 64'd0);

        // reset mid-burst discards partial burst and stale result
        send(32'd7, 1'b0, st);
        send(32'd8, 1'b0, st);
        hbus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_in_reset");
        tick();
        tick();
        check_reset_outputs("t6_held_reset");
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(32'd2, 1'b0, st);
        hbus.s_valid = 1'b0;
        wait_result("t6", 64'd8, 32'd2);
        tick();
        tick();
        check("t6_single_result", 64'(hbus.m_valid), 64'd0);
        check("t6_model_empty",   64'(q_sum.size()), 64'd0);

        // BURST_LEN=2 build
        b1[0] = 32'd3; b1[1] = 32'd4; b1[2] = 32'd5; b1[3] = 32'd6;
        hbus2.s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hbus2.s_data = b1[i];
            check("bl2_ready", 64'(hbus2.s_ready), 64'd1);
            tick();
        end
        hbus2.s_valid = 1'b0;
        repeat (3) tick();
        check("bl2_count", 64'(r2_sum.size()), 64'd2);
        if (r2_sum.size() == 2) begin
            check("bl2_r0_sum", r2_sum[0],      64'd7);
            check("bl2_r0_max", 64'(r2_max[0]), 64'd4);
            check("bl2_r1_sum", r2_sum[1],      64'd11);
            check("bl2_r1_max", 64'(r2_max[1]), 64'd6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_handshake_burst_accum
`default_nettype wire
